// File: rtl/rot16_seq_arb_if.sv
// Bus bundle for rot16_seq_arb: two rotate requesters, one response channel and the
// connection to the shared 16-bit combinational rotator.
//   req0_* / req1_* : valid/ready request with 16-bit operand and 4-bit right-rotate amount
//   rsp_*           : valid/ready result with 16-bit data and issuing requester id
//   rot_din/rot_ctl : operand and 6-bit select driven to the rotator
//   rot_dout        : rotator result, combinational from rot_din/rot_ctl
// Modports: slave = the arbiter/controller, master = requesters, consumer and rotator.
interface rot16_seq_arb_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [15:0] req0_data;
  logic [3:0]  req0_amt;
  logic        req1_valid;
  logic        req1_ready;
  logic [15:0] req1_data;
  logic [3:0]  req1_amt;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_id;
  logic [15:0] rot_din;
  logic [5:0]  rot_ctl;
  logic [15:0] rot_dout;

  modport slave (
    input  req0_valid, req0_data, req0_amt,
    input  req1_valid, req1_data, req1_amt,
    input  rsp_ready, rot_dout,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_data, rsp_id,
    output rot_din, rot_ctl
  );

  modport master (
    output req0_valid, req0_data, req0_amt,
    output req1_valid, req1_data, req1_amt,
    output rsp_ready, rot_dout,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_data, rsp_id,
    input  rot_din, rot_ctl
  );
endinterface

// File: rtl/rot16_seq_arb.sv
// rot16_seq_arb: arbitrates two rotate requesters onto a shared 16-bit rotator that only
// supports right-rotates by {0, 9..15}, and decomposes any amount 0..15 into a sequence
// of native one-cycle passes. The registered rotator output is fed back as the next input.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : rot16_seq_arb_if.slave (requests, response, rotator connection)
//   op_count   : (ROT16_SEQ_STATS_EN only) completed response handshakes, wrapping
//   pass_count : (ROT16_SEQ_STATS_EN only) rotator pass cycles, wrapping
// Parameter FIXED_PRIO: 0 = round-robin, 1 = requester 0 always wins contention.
// Optional statistics counters are enabled by defining the macro ROT16_SEQ_STATS_EN.
module rot16_seq_arb #(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  rot16_seq_arb_if.slave bus
`ifdef ROT16_SEQ_STATS_EN
  ,
  output logic [15:0]  op_count,
  output logic [15:0]  pass_count
`endif
);

  localparam bit FixedPrio = (FIXED_PRIO != 0);

  typedef enum logic [1:0] {StIdle, StRun, StResp} state_e;

  state_e      state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic [3:0]  rem_q, rem_d;
  logic        id_q, id_d;
  logic        last_q, last_d;

  logic any_valid;
  logic win1;
  logic native;

  // Rotator select for a native amount, written as {s21,s20,s19,s18,s17,s16}.
  function automatic logic [5:0] ctl_code(input logic [3:0] r);
    case (r)
      4'd0:    ctl_code = 6'b111000;
      4'd9:    ctl_code = 6'b000111;
      4'd10:   ctl_code = 6'b100011;
      4'd11:   ctl_code = 6'b010101;
      4'd12:   ctl_code = 6'b110001;
      4'd13:   ctl_code = 6'b001110;
      4'd14:   ctl_code = 6'b101010;
      4'd15:   ctl_code = 6'b011100;
      default: ctl_code = 6'b000000;
    endcase
  endfunction

  // Gated by rst_n so no ready can leak out while reset is held.
  assign any_valid = rst_n & (bus.req0_valid | bus.req1_valid);

  always_comb begin
    if (bus.req0_valid && bus.req1_valid) begin
      win1 = FixedPrio ? 1'b0 : ~last_q;
    end else begin
      win1 = bus.req1_valid;
    end
  end

  assign native = (rem_q == 4'd0) || (rem_q >= 4'd9);

  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    rem_d          = rem_q;
    id_d           = id_q;
    last_d         = last_q;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp_valid  = 1'b0;
    bus.rot_ctl    = 6'b000000;
    unique case (state_q)
      StIdle: begin
        if (any_valid) begin
          bus.req0_ready = ~win1;
          bus.req1_ready = win1;
          acc_d          = win1 ? bus.req1_data : bus.req0_data;
          rem_d          = win1 ? bus.req1_amt : bus.req0_amt;
          id_d           = win1;
          last_d         = win1;
          state_d        = StRun;
        end
      end
      StRun: begin
        acc_d = bus.rot_dout;
        if (native) begin
          bus.rot_ctl = ctl_code(rem_q);
          state_d     = StResp;
        end else begin
          // Non-native amounts peel off a rotate-by-9 and loop on the remainder.
          bus.rot_ctl = ctl_code(4'd9);
          rem_d       = rem_q - 4'd9;
        end
      end
      StResp: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.rot_din  = acc_q;
  assign bus.rsp_data = acc_q;
  assign bus.rsp_id   = id_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= 16'h0000;
      rem_q   <= 4'd0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;  // requester 0 wins the first contention
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

`ifdef ROT16_SEQ_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count   <= 16'h0000;
      pass_count <= 16'h0000;
    end else begin
      if (state_q == StResp && bus.rsp_ready) begin
        op_count <= op_count + 16'd1;
      end
      if (state_q == StRun) begin
        pass_count <= pass_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rot16_seq_arb.sv
// Self-checking bench for rot16_seq_arb. A round-robin instance is checked every cycle
// against a transaction-level model (direct rotate arithmetic plus a queue of expected
// passes) and by directed literal expectations; a fixed-priority instance is checked
// for requester-0-always-wins under constant contention.
module tb_rot16_seq_arb;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rot16_seq_arb_if bus ();
  rot16_seq_arb_if bus_fp ();

`ifdef ROT16_SEQ_STATS_EN
  logic [15:0] op_count, pass_count, op_count_fp, pass_count_fp;
`endif

  rot16_seq_arb #(.FIXED_PRIO(0)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef ROT16_SEQ_STATS_EN
    ,
    .op_count(op_count),
    .pass_count(pass_count)
`endif
  );

  rot16_seq_arb #(.FIXED_PRIO(1)) dut_fp (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus_fp)
`ifdef ROT16_SEQ_STATS_EN
    ,
    .op_count(op_count_fp),
    .pass_count(pass_count_fp)
`endif
  );

  function automatic logic [15:0] ror16(input logic [15:0] x, input int unsigned r);
    logic [31:0] t;
    t = {x, x} >> (r % 16);
    return t[15:0];
  endfunction

  // Behaviour of the external rotator: native amounts only, anything else gives zero.
  function automatic logic [15:0] rotator(input logic [15:0] din, input logic [5:0] ctl);
    case (ctl)
      6'b111000: return din;
      6'b000111: return ror16(din, 9);
      6'b100011: return ror16(din, 10);
      6'b010101: return ror16(din, 11);
      6'b110001: return ror16(din, 12);
      6'b001110: return ror16(din, 13);
      6'b101010: return ror16(din, 14);
      6'b011100: return ror16(din, 15);
      default:   return 16'h0000;
    endcase
  endfunction

  function automatic logic [5:0] code6(input int unsigned r);
    case (r)
      0:       return 6'b111000;
      9:       return 6'b000111;
      10:      return 6'b100011;
      11:      return 6'b010101;
      12:      return 6'b110001;
      13:      return 6'b001110;
      14:      return 6'b101010;
      15:      return 6'b011100;
      default: return 6'b000000;
    endcase
  endfunction

  assign bus.rot_dout    = rotator(bus.rot_din, bus.rot_ctl);
  assign bus_fp.rot_dout = rotator(bus_fp.rot_din, bus_fp.rot_ctl);

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- transaction-level model ----------------
  logic [15:0]  m_acc, m_result, m_din;
  logic         m_id, m_last, m_resp, m_g, m_any;
  int unsigned  m_q[$];
  int unsigned  m_amt, m_p;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      m_q.delete();
      m_resp = 1'b0;
      m_acc  = 16'h0000;
      m_id   = 1'b0;
      m_last = 1'b1;
      chk("reset rsp_valid", bus.rsp_valid, 0);
      chk("reset rot_ctl", bus.rot_ctl, 0);
      chk("reset rot_din", bus.rot_din, 0);
      chk("reset ready0", bus.req0_ready, 0);
      chk("reset ready1", bus.req1_ready, 0);
    end else begin
      chk("model rot_din", bus.rot_din, m_acc);
      if (m_q.size() > 0) begin
        chk("model run rot_ctl", bus.rot_ctl, code6(m_q[0]));
        chk("model run rsp_valid", bus.rsp_valid, 0);
        chk("model run ready0", bus.req0_ready, 0);
        chk("model run ready1", bus.req1_ready, 0);
        m_p   = m_q.pop_front();
        m_acc = ror16(m_acc, m_p);
        if (m_q.size() == 0) m_resp = 1'b1;
      end else if (m_resp) begin
        chk("model rsp_valid", bus.rsp_valid, 1);
        chk("model rsp_data", bus.rsp_data, m_result);
        chk("model rsp_id", bus.rsp_id, m_id);
        chk("model resp rot_ctl", bus.rot_ctl, 0);
        chk("model resp ready0", bus.req0_ready, 0);
        chk("model resp ready1", bus.req1_ready, 0);
        if (bus.rsp_ready) m_resp = 1'b0;
      end else begin
        m_any = bus.req0_valid | bus.req1_valid;
        m_g   = (bus.req0_valid && bus.req1_valid) ? ~m_last : bus.req1_valid;
        chk("model idle rsp_valid", bus.rsp_valid, 0);
        chk("model idle rot_ctl", bus.rot_ctl, 0);
        chk("model idle ready0", bus.req0_ready, m_any & ~m_g);
        chk("model idle ready1", bus.req1_ready, m_any & m_g);
        if (m_any) begin
          m_din    = m_g ? bus.req1_data : bus.req0_data;
          m_amt    = m_g ? bus.req1_amt : bus.req0_amt;
          m_acc    = m_din;
          m_result = ror16(m_din, m_amt);
          m_id     = m_g;
          m_last   = m_g;
          if (m_amt == 0 || m_amt >= 9) begin
            m_q.push_back(m_amt);
          end else if (m_amt == 1) begin
            m_q.push_back(9); m_q.push_back(9); m_q.push_back(15);
          end else begin
            m_q.push_back(9); m_q.push_back(m_amt + 7);
          end
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit who, input logic [15:0] d, input logic [3:0] a);
    bit got = 1'b0;
    if (!who) begin
      bus.req0_valid = 1'b1; bus.req0_data = d; bus.req0_amt = a;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_data = d; bus.req1_amt = a;
    end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = who ? bus.req1_ready : bus.req0_ready;
      tick();
    end
    if (!who) bus.req0_valid = 1'b0;
    else bus.req1_valid = 1'b0;
    if (!got) chk("accept timeout", 0, 1);
  endtask

  task automatic wait_rsp();
    bit got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) got = 1'b1;
      else tick();
    end
    if (!got) chk("response timeout", 0, 1);
  endtask

  int n_fp;

  initial begin
    rst_n = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_data = '0; bus.req0_amt = '0;
    bus.req1_valid = 1'b0; bus.req1_data = '0; bus.req1_amt = '0;
    bus.rsp_ready  = 1'b1;
    bus_fp.req0_valid = 1'b1; bus_fp.req0_data = 16'h1111; bus_fp.req0_amt = 4'd3;
    bus_fp.req1_valid = 1'b1; bus_fp.req1_data = 16'h2222; bus_fp.req1_amt = 4'd5;
    bus_fp.rsp_ready  = 1'b1;

    #12;
    chk("reset rsp_data", bus.rsp_data, 0);
    chk("reset rsp_id", bus.rsp_id, 0);
    chk("reset fp ready0", bus_fp.req0_ready, 0);
    chk("reset fp ready1", bus_fp.req1_ready, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // amt 0: single identity pass, response at accept+2
    issue(1'b0, 16'hA5A5, 4'd0);
    @(negedge clk);
    chk("amt0 rot_ctl", bus.rot_ctl, 6'b111000);
    chk("amt0 rot_din", bus.rot_din, 16'hA5A5);
    chk("amt0 early rsp_valid", bus.rsp_valid, 0);
    tick();
    @(negedge clk);
    chk("amt0 rsp_valid", bus.rsp_valid, 1);
    chk("amt0 rsp_data", bus.rsp_data, 16'hA5A5);
    chk("amt0 rsp_id", bus.rsp_id, 0);
    tick();

    // amt 9 from requester 1
    issue(1'b1, 16'h00FF, 4'd9);
    @(negedge clk);
    chk("amt9 rot_ctl", bus.rot_ctl, 6'b000111);
    tick();
    @(negedge clk);
    chk("amt9 rsp_data", bus.rsp_data, 16'h7F80);
    chk("amt9 rsp_id", bus.rsp_id, 1);
    tick();

    // amt 1: three passes 9, 9, 15
    issue(1'b0, 16'h0001, 4'd1);
    @(negedge clk);
    chk("amt1 pass1 rot_ctl", bus.rot_ctl, 6'b000111);
    tick();
    @(negedge clk);
    chk("amt1 pass2 rot_ctl", bus.rot_ctl, 6'b000111);
    tick();
    @(negedge clk);
    chk("amt1 pass3 rot_ctl", bus.rot_ctl, 6'b011100);
    tick();
    @(negedge clk);
    chk("amt1 rsp_valid", bus.rsp_valid, 1);
    chk("amt1 rsp_data", bus.rsp_data, 16'h8000);
    tick();

    // backpressure: response held while both requesters wait
    bus.rsp_ready = 1'b0;
    issue(1'b0, 16'h1234, 4'd4);
    wait_rsp();
    tick();
    bus.req0_valid = 1'b1; bus.req0_data = 16'hBEEF; bus.req0_amt = 4'd2;
    bus.req1_valid = 1'b1; bus.req1_data = 16'hCAFE; bus.req1_amt = 4'd7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold rsp_valid", bus.rsp_valid, 1);
      chk("hold rsp_data", bus.rsp_data, 16'h4123);
      chk("hold rsp_id", bus.rsp_id, 0);
      chk("hold ready0", bus.req0_ready, 0);
      chk("hold ready1", bus.req1_ready, 0);
      chk("hold rot_ctl", bus.rot_ctl, 0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("handshake cycle ready0", bus.req0_ready, 0);
    chk("handshake cycle ready1", bus.req1_ready, 0);
    tick();
    @(negedge clk);
    chk("post-handshake grant1", bus.req1_ready, 1);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    repeat (5) tick();

    // round-robin under constant contention
    bus.req0_valid = 1'b1; bus.req0_data = 16'h1357; bus.req0_amt = 4'd3;
    bus.req1_valid = 1'b1; bus.req1_data = 16'h2468; bus.req1_amt = 4'd12;
    for (int k = 0; k < 4; k++) begin
      bit got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
        @(negedge clk);
        if (bus.req0_ready || bus.req1_ready) begin
          got = 1'b1;
          chk("rr grant is req1", bus.req1_ready, k % 2);
        end
        tick();
      end
      if (!got) chk("rr grant timeout", 0, 1);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    repeat (6) tick();

    // fixed priority instance: requester 0 always wins
    n_fp = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (bus_fp.req0_ready || bus_fp.req1_ready) begin
        n_fp++;
        chk("fixed grant ready0", bus_fp.req0_ready, 1);
        chk("fixed grant ready1", bus_fp.req1_ready, 0);
      end
      if (bus_fp.rsp_valid) begin
        chk("fixed rsp_data", bus_fp.rsp_data, 16'h2222);
        chk("fixed rsp_id", bus_fp.rsp_id, 0);
      end
      tick();
    end
    chk("fixed grants seen", n_fp >= 3, 1);

    // reset during the second pass of amt 1 aborts the operation
    issue(1'b0, 16'h0001, 4'd1);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort rsp_valid", bus.rsp_valid, 0);
    chk("abort rot_ctl", bus.rot_ctl, 0);
    chk("abort rot_din", bus.rot_din, 0);
    chk("abort rsp_data", bus.rsp_data, 0);
    chk("abort rsp_id", bus.rsp_id, 0);
    chk("abort ready0", bus.req0_ready, 0);
    tick();
    rst_n = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_data = 16'h0F0F; bus.req0_amt = 4'd4;
    bus.req1_valid = 1'b1; bus.req1_data = 16'hF00F; bus.req1_amt = 4'd15;
    @(negedge clk);
    chk("first contention ready0", bus.req0_ready, 1);
    chk("first contention ready1", bus.req1_ready, 0);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    wait_rsp();
    chk("fresh rsp_data", bus.rsp_data, 16'hF0F0);
    chk("fresh rsp_id", bus.rsp_id, 0);
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
